cdb_arbiter: RTL and testbench

Completion-side arbiter between the functional units and the common data bus. Each result-producing FU (ALU, MULT, LOAD) deposits a finished result into its own one-entry holding buffer. A round-robin arbiter picks one buffer per cycle, broadcasts its destination PREG and value on the CDB, and pulses the matching per-class free line. Downstream, the CDB drives the reservation station's `update`/`ready_reg` inputs, and the free lines drive its `free_alu`/`free_mult`/`free_load` inputs.

---
 rtl/sys_defs.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/cdb_arbiter.sv | 105 ++++++++++
 tb/tb_cdb_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared processor definitions: physical-register tag, datapath width,
// functional-unit counts and the common-data-bus packet.
package sys_defs;

  localparam int XLEN        = 32;
  localparam int PREG_W      = 6;
  localparam int NUM_FU_ALU  = 2;
  localparam int NUM_FU_MULT = 1;
  localparam int NUM_FU_LOAD = 1;

  typedef logic [PREG_W-1:0] PREG;

  typedef struct packed {
    logic            valid;
    PREG             preg;
    logic [XLEN-1:0] value;
  } CDB_PACKET;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: grants the first asserted request at or
// above ptr, wrapping past N-1 back to 0. Reusable for RS issue selection.
module rr_arbiter #(
  parameter int  N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] w_cand;

  // NOTE: every output of this block is assigned a default before the loop, so no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_cand  = '0;
    // Walk from the farthest candidate to the nearest; the nearest hit overwrites.
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = W'((int'(ptr) + k) % N);
      if (req[w_cand]) begin
        gnt         = '0;
        gnt[w_cand] = 1'b1;
        gnt_idx     = w_cand;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Completion-side arbiter: one-entry holding buffer per FU, round-robin pick of
// one buffer per cycle onto the CDB, with a per-class free pulse for the winner.
module cdb_arbiter #(
  parameter int  NUM_ALU  = sys_defs::NUM_FU_ALU,
  parameter int  NUM_MULT = sys_defs::NUM_FU_MULT,
  parameter int  NUM_LOAD = sys_defs::NUM_FU_LOAD,
  parameter int  XLEN     = sys_defs::XLEN,
  localparam int NUM_REQ  = NUM_ALU + NUM_MULT + NUM_LOAD,
  localparam int PREG_W   = sys_defs::PREG_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic [NUM_REQ-1:0]             fu_done,
  input  logic [NUM_REQ-1:0][PREG_W-1:0] fu_dest,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   fu_value,
  output logic [NUM_REQ-1:0]             fu_stall,
  output logic                           cdb_valid,
  output logic [PREG_W-1:0]              cdb_preg,
  output logic [XLEN-1:0]                cdb_value,
  output logic [NUM_ALU-1:0]             free_alu,
  output logic [NUM_MULT-1:0]            free_mult,
  output logic [NUM_LOAD-1:0]            free_load
);

  localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int               MULT_BASE = NUM_ALU;
  localparam int               LOAD_BASE = NUM_ALU + NUM_MULT;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]             r_buf_valid;
  logic [NUM_REQ-1:0][PREG_W-1:0] r_buf_dest;
  logic [NUM_REQ-1:0][XLEN-1:0]   r_buf_value;
  logic [PTR_W-1:0]               r_rr_ptr;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [NUM_REQ-1:0]  w_bcast;
  logic [NUM_REQ-1:0]  w_load;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic [PTR_W-1:0]    w_ptr_next;
  logic                w_any;
  sys_defs::CDB_PACKET w_cdb;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (r_buf_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // A squash kills the broadcast and releases every FU in the same cycle.
  assign w_bcast    = squash ? '0 : w_gnt;
  assign w_any      = |w_bcast;
  assign fu_stall   = squash ? '0 : (r_buf_valid & ~w_gnt);
  assign w_load     = fu_done & ~fu_stall;
  assign w_ptr_next = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + PTR_W'(1);

  always_comb begin
    w_cdb = '0;
    if (w_any) begin
      w_cdb.valid = 1'b1;
      w_cdb.preg  = r_buf_dest[w_gnt_idx];
      w_cdb.value = sys_defs::XLEN'(r_buf_value[w_gnt_idx]);
    end
  end

  assign cdb_valid = w_cdb.valid;
  assign cdb_preg  = w_cdb.preg;
  assign cdb_value = XLEN'(w_cdb.value);

  // Requesters are laid out ALU, then MULT, then LOAD, so the one-hot grant splits by slice.
  assign free_alu  = w_bcast[NUM_ALU-1:0];
  assign free_mult = w_bcast[MULT_BASE +: NUM_MULT];
  assign free_load = w_bcast[LOAD_BASE +: NUM_LOAD];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset || squash) begin
      r_buf_valid <= '0;
      r_rr_ptr    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_load[i]) begin
          r_buf_valid[i] <= 1'b1;
        end else if (w_gnt[i]) begin
          r_buf_valid[i] <= 1'b0;
        end
      end
      if (w_any) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  // NOTE: payload registers are deliberately not reset; they are only observed when r_buf_valid is set.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_load[i]) begin
        r_buf_dest[i]  <= fu_dest[i];
        r_buf_value[i] <= fu_value[i];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the holding buffers and rotating priority.
module tb_cdb_arbiter;

  localparam int NR = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic                squash;
  logic [NR-1:0]       fu_done;
  logic [NR-1:0][5:0]  fu_dest;
  logic [NR-1:0][31:0] fu_value;
  logic [NR-1:0]       fu_stall;
  logic                cdb_valid;
  logic [5:0]          cdb_preg;
  logic [31:0]         cdb_value;
  logic [1:0]          free_alu;
  logic [0:0]          free_mult;
  logic [0:0]          free_load;
  logic [3:0]          free_all;

  int errors = 0;
  int checks = 0;

  // Model: what each FU's holding slot contains and whose turn comes first.
  bit          m_valid[NR];
  logic [5:0]  m_dest[NR];
  logic [31:0] m_value[NR];
  int          m_ptr = 0;

  assign free_all = {free_load, free_mult, free_alu};

  cdb_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .fu_done   (fu_done),
    .fu_dest   (fu_dest),
    .fu_value  (fu_value),
    .fu_stall  (fu_stall),
    .cdb_valid (cdb_valid),
    .cdb_preg  (cdb_preg),
    .cdb_value (cdb_value),
    .free_alu  (free_alu),
    .free_mult (free_mult),
    .free_load (free_load)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Winner this cycle per the rules: first full slot from the turn pointer, with wrap.
  function automatic int exp_grant();
    if (squash) return -1;
    for (int k = 0; k < NR; k++) begin
      int i = (m_ptr + k) % NR;
      if (m_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    int            g;
    logic [NR-1:0] stall;
    g = exp_grant();
    for (int i = 0; i < NR; i++) stall[i] = !squash && m_valid[i] && (i != g);
    @(posedge clock);
    if (!reset || squash) begin
      for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
      m_ptr = 0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (fu_done[i] && !stall[i]) begin
          m_valid[i] = 1'b1;
          m_dest[i]  = fu_dest[i];
          m_value[i] = fu_value[i];
        end else if (i == g) begin
          m_valid[i] = 1'b0;
        end
      end
      if (g >= 0) m_ptr = (g + 1) % NR;
    end
    #1;
  endtask

  task automatic idle();
    reset    = 1'b1;
    squash   = 1'b0;
    fu_done  = '0;
    fu_dest  = '0;
    fu_value = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_cdb_valid: got %b want 0", cdb_valid); end
    checks++;
    if ({cdb_preg, cdb_value} !== 38'd0) begin errors++; $display("FAIL reset_cdb_data: got %h/%h want 0/0", cdb_preg, cdb_value); end
    checks++;
    if (free_all !== 4'b0000) begin errors++; $display("FAIL reset_free: got %b want 0000", free_all); end
    checks++;
    if (fu_stall !== 4'b0000) begin errors++; $display("FAIL reset_stall: got %b want 0000", fu_stall); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    fu_done     = 4'b0001;
    fu_dest[0]  = 6'd5;
    fu_value[0] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (fu_stall !== 4'b0000) begin errors++; $display("FAIL single_capture_stall: got %b want 0000", fu_stall); end
    tick();
    fu_done = '0;
    #1;
    checks++;
    if ({cdb_valid, cdb_preg, cdb_value} !== {1'b1, 6'd5, 32'hDEAD_BEEF})
      begin errors++; $display("FAIL single_bcast: got %b/%0d/%h want 1/5/deadbeef", cdb_valid, cdb_preg, cdb_value); end
    checks++;
    if (free_all !== 4'b0001) begin errors++; $display("FAIL single_free: got %b want 0001", free_all); end
    tick();
    #1;
    checks++;
    if ({cdb_valid, cdb_preg, cdb_value, free_all, fu_stall} !== '0)
      begin errors++; $display("FAIL single_after: got %b/%0d/%h/%b/%b want all 0", cdb_valid, cdb_preg, cdb_value, free_all, fu_stall); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_stall;
    logic [3:0] exp_free;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      fu_dest[i]  = 6'(i + 1);
      fu_value[i] = 32'h100 + 32'(i);
    end
    fu_done = 4'b1111;
    #1;
    checks++;
    if (fu_stall !== 4'b0000) begin errors++; $display("FAIL rr_capture_stall: got %b want 0000", fu_stall); end
    tick();
    fu_done = '0;
    for (int k = 0; k < NR; k++) begin
      #1;
      exp_stall = 4'b1110 << k;
      exp_free  = 4'b0001 << k;
      checks++;
      if ({cdb_valid, cdb_preg, cdb_value} !== {1'b1, 6'(k + 1), 32'h100 + 32'(k)})
        begin errors++; $display("FAIL rr_bcast%0d: got %b/%0d/%h want 1/%0d/%h", k, cdb_valid, cdb_preg, cdb_value, k + 1, 32'h100 + 32'(k)); end
      checks++;
      if (fu_stall !== exp_stall) begin errors++; $display("FAIL rr_stall%0d: got %b want %b", k, fu_stall, exp_stall); end
      checks++;
      if (free_all !== exp_free) begin errors++; $display("FAIL rr_free%0d: got %b want %b", k, free_all, exp_free); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      fu_done     = (c < 3) ? 4'b0100 : 4'b0000;
      fu_dest[2]  = 6'(10 + c);
      fu_value[2] = 32'hB000 + 32'(c);
      #1;
      if (c >= 1 && c <= 3) begin
        checks++;
        if ({cdb_valid, cdb_preg, cdb_value} !== {1'b1, 6'(9 + c), 32'hB000 + 32'(c - 1)})
          begin errors++; $display("FAIL b2b_bcast%0d: got %b/%0d/%h want 1/%0d", c, cdb_valid, cdb_preg, cdb_value, 9 + c); end
        checks++;
        if ({fu_stall[2], free_mult} !== 2'b01)
          begin errors++; $display("FAIL b2b_flow%0d: got stall=%b free_mult=%b want 0/1", c, fu_stall[2], free_mult); end
      end else begin
        checks++;
        if ({cdb_valid, free_all} !== 5'b0)
          begin errors++; $display("FAIL b2b_idle%0d: got valid=%b free=%b want 0/0000", c, cdb_valid, free_all); end
      end
      tick();
    end
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    fu_done    = 4'b0100;
    fu_dest[2] = 6'd7;
    #1;
    tick();
    fu_done    = 4'b1001;
    fu_dest[0] = 6'd40;
    fu_dest[3] = 6'd43;
    #1;
    checks++;
    if ({cdb_valid, cdb_preg} !== {1'b1, 6'd7}) begin errors++; $display("FAIL wrap_setup: got %b/%0d want 1/7", cdb_valid, cdb_preg); end
    tick();
    fu_done = '0;
    #1;
    checks++;
    if (dut.r_rr_ptr !== 2'd3) begin errors++; $display("FAIL wrap_ptr3: got %0d want 3", dut.r_rr_ptr); end
    checks++;
    if ({cdb_valid, cdb_preg, free_all} !== {1'b1, 6'd43, 4'b1000})
      begin errors++; $display("FAIL wrap_grant3: got %b/%0d/%b want 1/43/1000", cdb_valid, cdb_preg, free_all); end
    tick();
    #1;
    checks++;
    if (dut.r_rr_ptr !== 2'd0) begin errors++; $display("FAIL wrap_ptr0: got %0d want 0", dut.r_rr_ptr); end
    checks++;
    if ({cdb_valid, cdb_preg, free_all} !== {1'b1, 6'd40, 4'b0001})
      begin errors++; $display("FAIL wrap_grant0: got %b/%0d/%b want 1/40/0001", cdb_valid, cdb_preg, free_all); end
    tick();
    #1;
    checks++;
    if ({dut.r_rr_ptr, cdb_valid} !== {2'd1, 1'b0})
      begin errors++; $display("FAIL wrap_ptr1: got ptr=%0d valid=%b want 1/0", dut.r_rr_ptr, cdb_valid); end
  endtask

  task automatic test_squash();
    do_reset();
    fu_done    = 4'b0011;
    fu_dest[0] = 6'd20;
    fu_dest[1] = 6'd21;
    #1;
    tick();
    fu_done    = 4'b0100;
    fu_dest[2] = 6'd22;
    squash     = 1'b1;
    #1;
    checks++;
    if ({cdb_valid, free_all, fu_stall} !== 9'b0)
      begin errors++; $display("FAIL squash_cycle: got valid=%b free=%b stall=%b want 0", cdb_valid, free_all, fu_stall); end
    tick();
    squash  = 1'b0;
    fu_done = '0;
    #1;
    checks++;
    if ({cdb_valid, free_all} !== 5'b0)
      begin errors++; $display("FAIL squash_after: got valid=%b free=%b want 0/0000", cdb_valid, free_all); end
    checks++;
    if ({dut.r_rr_ptr, dut.r_buf_valid} !== 6'b0)
      begin errors++; $display("FAIL squash_state: got ptr=%0d bufs=%b want 0/0000", dut.r_rr_ptr, dut.r_buf_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    fu_done    = 4'b1101;
    fu_dest[0] = 6'd50;
    fu_dest[2] = 6'd52;
    fu_dest[3] = 6'd53;
    #1;
    tick();
    fu_done = '0;
    #1;
    checks++;
    if (fu_stall !== 4'b1100) begin errors++; $display("FAIL rstmid_stall: got %b want 1100", fu_stall); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({cdb_valid, cdb_preg, cdb_value, free_all, fu_stall} !== '0)
      begin errors++; $display("FAIL rstmid_outputs: got %b/%0d/%h/%b/%b want all 0", cdb_valid, cdb_preg, cdb_value, free_all, fu_stall); end
    checks++;
    if (dut.r_buf_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_bufs: got %b want 0000", dut.r_buf_valid); end
    fu_done     = 4'b0010;
    fu_dest[1]  = 6'd61;
    fu_value[1] = 32'h6161;
    #1;
    tick();
    fu_done = '0;
    #1;
    checks++;
    if ({cdb_valid, cdb_preg, cdb_value, free_all} !== {1'b1, 6'd61, 32'h6161, 4'b0010})
      begin errors++; $display("FAIL rstmid_new: got %b/%0d/%h/%b want 1/61/6161/0010", cdb_valid, cdb_preg, cdb_value, free_all); end
    tick();
  endtask

  task automatic test_random();
    logic [NR-1:0] hold;
    logic [NR-1:0] exp_stall;
    logic [3:0]    exp_free;
    logic [38:0]   exp_bus;
    int            g;
    hold = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset  = ($urandom_range(0, 63) != 0);
      squash = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!hold[i]) begin
          fu_done[i]  = 1'($urandom_range(0, 1));
          fu_dest[i]  = 6'($urandom);
          fu_value[i] = $urandom;
        end
      end
      #1;
      g         = exp_grant();
      exp_bus   = (g >= 0) ? {1'b1, m_dest[g], m_value[g]} : 39'd0;
      exp_free  = (g >= 0) ? 4'(1 << g) : 4'd0;
      for (int i = 0; i < NR; i++) exp_stall[i] = !squash && m_valid[i] && (i != g);
      checks++;
      if ({cdb_valid, cdb_preg, cdb_value} !== exp_bus)
        begin errors++; $display("FAIL rand_bus%0d: got %b/%0d/%h want %h", c, cdb_valid, cdb_preg, cdb_value, exp_bus); end
      checks++;
      if (free_all !== exp_free) begin errors++; $display("FAIL rand_free%0d: got %b want %b", c, free_all, exp_free); end
      checks++;
      if (fu_stall !== exp_stall) begin errors++; $display("FAIL rand_stall%0d: got %b want %b", c, fu_stall, exp_stall); end
      checks++;
      if (dut.r_rr_ptr !== 2'(m_ptr)) begin errors++; $display("FAIL rand_ptr%0d: got %0d want %0d", c, dut.r_rr_ptr, m_ptr); end
      hold = reset ? (fu_done & exp_stall) : '0;
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_pointer_wrap();
    test_squash();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
